// File: rtl/synth_audio_pkg.sv
// Shared constants and drain FSM encoding for the synth audio output path.
// No logic; widths and the 48 kHz divider live here so producer and feeder agree.
// Backpressure: n/a.
package synth_audio_pkg;
    localparam int SAMPLE_W    = 16;
    localparam int CLK_DIV_48K = 1042;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } drain_state_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with read-ahead head data for audio samples.
// Latency: push visible at head and in level on the next edge.
// Backpressure: push while full is accepted only together with a pop.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO frees the head slot in the same edge it is popped, so the
    // write pointer (equal to the read pointer) can safely take the new sample.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/audio_out_feeder.sv
// Paces attenuated synth samples at a fixed tick into the DAC write strobe.
// Latency: tick at T, FIFO level at T+1, write strobe at T+2 when idle and allowed.
// Backpressure: audio_out_allowed gates drain; full FIFO drops tick samples (sticky overflow).
module audio_out_feeder #(
    parameter int CLK_DIV    = synth_audio_pkg::CLK_DIV_48K,
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_W   = synth_audio_pkg::SAMPLE_W
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic [2:0]                    vol_shift,
    input  logic                          mute,
    output logic                          sample_req,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic [31:0]                   left_channel_audio_out,
    output logic [31:0]                   right_channel_audio_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_status
);
    import synth_audio_pkg::*;

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0]              div_cnt;
    logic                       tick;
    logic signed [SAMPLE_W-1:0] scaled;
    logic [SAMPLE_W-1:0]        push_dat;
    logic [SAMPLE_W-1:0]        head_dat;
    logic [SAMPLE_W-1:0]        chan_dat;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       drop;
    logic                       load;
    drain_state_t               state;
    drain_state_t               state_nxt;

    always_ff @(posedge CLOCK_50) begin
        if (reset || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign sample_req = tick;

    assign scaled   = $signed(sample_in) >>> vol_shift;
    assign push_dat = mute ? '0 : scaled;

    assign pop  = (state == WRITE) && !fifo_empty;
    assign drop = tick && fifo_full && !pop;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (tick),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The GAP state gives the controller a cycle to drop allowed after a write.
    always_comb begin
        state_nxt       = state;
        load            = 1'b0;
        write_audio_out = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && audio_out_allowed) begin
                    load      = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                write_audio_out = 1'b1;
                state_nxt       = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            chan_dat <= '0;
        end else if (load) begin
            chan_dat <= head_dat;
        end
    end

    assign left_channel_audio_out  = {chan_dat, {(32-SAMPLE_W){1'b0}}};
    assign right_channel_audio_out = {chan_dat, {(32-SAMPLE_W){1'b0}}};

    // A drop in the same cycle as clear_status must remain visible.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_status) begin
            overflow <= 1'b0;
        end
    end
endmodule
